data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Responder side of the MIPS core's data-memory interface. It accepts one
//   load or store per request/ready handshake and serves it from an internal
//   word array after a programmable number of wait states.
//   It replaces the ideal zero-latency data memory behind the datapath's
//   aluout/writedata/readdata path, so stall logic can be exercised.
// PARAMETERS
//   BASE     32'h10010000  byte address of word 0 (MIPS .data segment)
//   DEPTH    1024          number of 32-bit words in the array (power of 2)
//   LATENCY  2             wait-state cycles between acceptance and ready (0..15)
// PORTS
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-high reset
//   req    in   1   initiator requests a transfer; held until ready
//   we     in   1   1 = store, 0 = load; stable while req=1
//   addr   in   32  byte address (aluout); stable while req=1
//   wdata  in   32  store data (writedata); stable while req=1
//   rdata  out  32  load data (readdata); valid only while ready=1
//   ready  out  1   one-cycle pulse: transfer complete
//   err    out  1   qualifies ready: request was misaligned or out of range
// BEHAVIOUR
//   Reset (async, active-high):
//     - state=IDLE, ready=0, err=0, rdata=0, wait counter=0
//     - array contents are NOT cleared
//     - reset asserted mid-transfer aborts it; an uncommitted store is dropped
//   FSM states are IDLE, WAIT and RESP.
//     - IDLE: when req=1, latch we/addr/wdata and decode the address.
//       Go to WAIT with cnt=LATENCY, or go directly to RESP if LATENCY=0.
//     - WAIT: decrement cnt each cycle; move to RESP the cycle after cnt reaches 1.
//     - RESP: ready=1 for exactly one cycle, then return to IDLE.
//       req is ignored in RESP, even if the initiator already holds the next request.
//   Latency and throughput:
//     - request accepted in cycle t -> ready=1 in cycle t+1+LATENCY
//     - back-to-back requests complete every LATENCY+2 cycles
//   Address decode uses the latched addr:
//     - misaligned: addr[1:0]!=0
//     - out of range: addr<BASE or addr>=BASE+4*DEPTH (compare in 33 bits, no wrap)
//     - index = (addr-BASE)>>2, truncated to log2(DEPTH) bits
//   Store commit:
//     - a store writes the array on the clock edge that enters RESP
//     - a store with an error does not write
//   Load data:
//     - rdata is registered on entry to RESP
//     - error-free load: rdata = array[index]
//     - load or store with an error: rdata=0
//     - store with no error: rdata=0
//     - outside RESP, rdata returns to 0
//   err:
//     - err=1 only together with ready=1; err=0 otherwise
//   Latched copy:
//     - changes to addr, wdata or we after acceptance have no effect
//   req dropped before ready (protocol violation): the transfer still completes
//     from the latched copy, ready pulses, and the block returns to IDLE.
// TESTING
//   1. Store then load, LATENCY=2:
//      store wdata=32'hDEADBEEF to addr=32'h10010008, then load the same address
//      -> each ready pulses 3 cycles after acceptance; load returns rdata=32'hDEADBEEF, err=0.
//   2. Boundary addresses:
//      store then load addr=BASE and addr=BASE+4*DEPTH-4 -> both succeed.
//      Load addr=BASE+4*DEPTH and addr=BASE-4 -> ready with err=1, rdata=0.
//   3. Misaligned store:
//      store to addr=32'h10010002 -> err=1.
//      Reloading word 32'h10010000 shows its previous value unchanged.
//   4. LATENCY=0, back-to-back:
//      req held high for 4 consecutive loads -> ready pulses every 2 cycles,
//      and ready is never high on two consecutive cycles.
//   5. Reset mid-WAIT:
//      assert reset during the WAIT of a store to 32'h10010010 -> ready/err/rdata go 0
//      immediately (async); a later load of that address returns the old data.
//   6. Input change after acceptance:
//      change addr/wdata the cycle after acceptance -> the original latched address
//      and data are used.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the core (master) and the responder (slave).
// Carries one load/store request and its completion pulse, error flag and load data.
// The master holds req and its payload until ready pulses.
interface data_memory_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/data_memory_responder.sv
// Word-array data memory answering one load/store per req/ready handshake.
// Latency: acceptance in cycle t gives a one-cycle ready pulse in cycle t+1+LATENCY.
// Backpressure: the initiator holds req until ready; req is ignored in WAIT and RESP.
module data_memory_responder #(
  parameter logic [31:0] BASE    = 32'h10010000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input logic                      clk,
  input logic                      reset,
  data_memory_responder_if.slave   bus
);
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic          ready;
  logic          err;
  logic [31:0]   rdata;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          cur_we;
  logic          cur_bad;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [IW-1:0] cur_idx;

  assign accept = (state == IDLE) && bus.req;

  // With zero wait states the commit edge is the acceptance edge itself, so the
  // transfer is decoded from the live bus in IDLE and from the latched copy afterwards.
  assign cur_we    = (state == IDLE) ? bus.we    : lat_we;
  assign cur_addr  = (state == IDLE) ? bus.addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? bus.wdata : lat_wdata;

  // Range check in 33 bits so BASE+4*DEPTH cannot wrap.
  assign cur_bad = (cur_addr[1:0] != 2'b00) ||
                   ({1'b0, cur_addr} < {1'b0, BASE}) ||
                   ({1'b0, cur_addr} >= LIMIT);
  assign cur_idx = IW'((cur_addr - BASE) >> 2);

  assign enter_resp = (accept && (LAT == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));

  assign bus.ready = ready;
  assign bus.err   = err;
  assign bus.rdata = rdata;

  // Control FSM, request latch and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      ready <= enter_resp;
      err   <= enter_resp && cur_bad;
      rdata <= (enter_resp && !cur_we && !cur_bad) ? mem[cur_idx] : 32'd0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            lat_we    <= bus.we;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            if (LAT == 4'd0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= LAT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit on the edge that enters RESP; the array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_we && !cur_bad) mem[cur_idx] <= cur_wdata;
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one LATENCY=2 instance and one LATENCY=0 instance.
// Expected responses are predicted at issue time into per-instance queues and popped on ready.
// Every bounded wait that expires is reported as a failed comparison.
module tb_data_memory_responder;
  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 1024;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  exp_t        sb2[$];
  exp_t        sb0[$];
  logic [31:0] model2 [int];
  logic [31:0] model0 [int];

  data_memory_responder_if b2 ();
  data_memory_responder_if b0 ();

  data_memory_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .bus(b2.slave));
  data_memory_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .bus(b0.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of one transfer; updates the word model on a good store.
  function automatic exp_t predict(input bit sel, input logic w, input logic [31:0] a,
                                   input logic [31:0] d);
    exp_t e;
    logic bad;
    int   idx;
    bad = (a[1:0] != 2'b00) || (a < BASE) || ({1'b0, a} >= ({1'b0, BASE} + 33'h1000));
    idx = int'((a - BASE) >> 2);
    e.err   = bad;
    e.rdata = 32'd0;
    if (!bad) begin
      if (w) begin
        if (sel) model0[idx] = d; else model2[idx] = d;
      end else if (sel) begin
        e.rdata = model0.exists(idx) ? model0[idx] : 32'hxxxxxxxx;
      end else begin
        e.rdata = model2.exists(idx) ? model2[idx] : 32'hxxxxxxxx;
      end
    end
    return e;
  endfunction

  task automatic pop_check(input bit sel, input string tag, input logic e, input logic [31:0] r);
    exp_t x;
    int   sz;
    sz = sel ? sb0.size() : sb2.size();
    check({tag, "_sb"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (sel) x = sb0.pop_front(); else x = sb2.pop_front();
      check({tag, "_err"}, 32'(e), 32'(x.err));
      check({tag, "_rdata"}, r, x.rdata);
    end
  endtask

  // One transfer on the LATENCY=2 instance; optionally alters addr/wdata after acceptance.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag,
                      input bit chg = 1'b0, input logic [31:0] ca = 32'd0,
                      input logic [31:0] cd = 32'd0);
    int n;
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d;
    sb2.push_back(predict(1'b0, w, a, d));
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (chg && n == 1) begin b2.addr = ca; b2.wdata = cd; end
    end while (!b2.ready && n < 20);
    check({tag, "_lat"}, 32'(n), 32'd3);
    if (b2.ready) pop_check(1'b0, tag, b2.err, b2.rdata);
    b2.req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, {31'd0, b2.ready}, 32'd0);
    check({tag, "_rdata_idle"}, b2.rdata, 32'd0);
  endtask

  // Four transfers on the LATENCY=0 instance with req held high throughout.
  task automatic burst0(input logic w, input string tag);
    logic [31:0] a [4];
    logic [31:0] d [4];
    int   k, n, last;
    logic prev;
    a[0] = BASE; a[1] = BASE + 32'd4; a[2] = BASE + 32'd8; a[3] = BASE + 32'd12;
    d[0] = 32'h0000AAAA; d[1] = 32'h1111BBBB; d[2] = 32'h2222CCCC; d[3] = 32'h3333DDDD;
    k = 0; n = 0; last = 0; prev = 1'b0;
    b0.req = 1'b1; b0.we = w; b0.addr = a[0]; b0.wdata = d[0];
    sb0.push_back(predict(1'b1, w, a[0], d[0]));
    while (k < 4 && n < 40) begin
      @(posedge clk); #1; n++;
      check({tag, "_no_consec"}, {31'd0, b0.ready & prev}, 32'd0);
      prev = b0.ready;
      if (b0.ready) begin
        check({tag, "_gap"}, 32'(n - last), (k == 0) ? 32'd1 : 32'd2);
        last = n;
        pop_check(1'b1, tag, b0.err, b0.rdata);
        k++;
        if (k < 4) begin
          b0.addr = a[k]; b0.wdata = d[k];
          sb0.push_back(predict(1'b1, w, a[k], d[k]));
        end else begin
          b0.req = 1'b0;
        end
      end
    end
    check({tag, "_count"}, 32'(k), 32'd4);
    b0.req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    b2.req = 1'b0; b2.we = 1'b0; b2.addr = 32'd0; b2.wdata = 32'd0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = 32'd0; b0.wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, b2.ready}, 32'd0);
    check("rst_err", {31'd0, b2.err}, 32'd0);
    check("rst_rdata", b2.rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Store then load at LATENCY=2.
    xfer(1'b1, 32'h10010008, 32'hDEADBEEF, "st_beef");
    xfer(1'b0, 32'h10010008, 32'd0, "ld_beef");

    // Boundary addresses.
    xfer(1'b1, BASE, 32'hA5A5A5A5, "st_base");
    xfer(1'b1, BASE + 32'h0FFC, 32'h5A5A5A5A, "st_top");
    xfer(1'b0, BASE, 32'd0, "ld_base");
    xfer(1'b0, BASE + 32'h0FFC, 32'd0, "ld_top");
    xfer(1'b0, BASE + 32'h1000, 32'd0, "ld_above");
    xfer(1'b0, BASE - 32'd4, 32'd0, "ld_below");

    // Misaligned store must not disturb word 0.
    xfer(1'b1, 32'h10010002, 32'h12345678, "st_misalign");
    xfer(1'b0, BASE, 32'd0, "ld_base_again");

    // Zero wait states, back-to-back with req held.
    burst0(1'b1, "b2b_st");
    burst0(1'b0, "b2b_ld");

    // Reset during WAIT drops the pending store.
    xfer(1'b1, 32'h10010010, 32'h11111111, "st_old");
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h10010010; b2.wdata = 32'h22222222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rstw_ready", {31'd0, b2.ready}, 32'd0);
    check("rstw_err", {31'd0, b2.err}, 32'd0);
    check("rstw_rdata", b2.rdata, 32'd0);
    b2.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstw_no_pulse", {31'd0, b2.ready}, 32'd0);
    xfer(1'b0, 32'h10010010, 32'd0, "ld_old");

    // Reset during RESP clears the outputs without waiting for a clock edge.
    b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h10010008; b2.wdata = 32'd0;
    sb2.push_back(predict(1'b0, 1'b0, 32'h10010008, 32'd0));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b2.ready && n < 20);
    check("rstr_seen", {31'd0, b2.ready}, 32'd1);
    if (b2.ready) pop_check(1'b0, "rstr", b2.err, b2.rdata);
    b2.req = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("rstr_ready", {31'd0, b2.ready}, 32'd0);
    check("rstr_rdata", b2.rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Inputs changed after acceptance are ignored.
    xfer(1'b1, 32'h10010020, 32'hCAFEF00D, "st_latch", 1'b1, 32'h10010008, 32'h0BADF00D);
    xfer(1'b0, 32'h10010020, 32'd0, "ld_latch");
    xfer(1'b0, 32'h10010008, 32'd0, "ld_latch_other");

    check("sb2_drained", 32'(sb2.size()), 32'd0);
    check("sb0_drained", 32'(sb0.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
